// File: rtl/dmem_sized_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_sized_ctrl
// Brief    : Byte-addressed, big-endian data memory with byte, halfword,
//            word and two-beat doubleword access. Sub-word reads can be
//            sign-extended. Misaligned accesses are flagged and rejected.
//            An optional preload sequencer fills memory from a byte stream
//            after reset. It is enabled by defining DMEM_PRELOAD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_sized_ctrl #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_Enable,
  input  logic                  i_ReadWrite,
  input  logic                  i_SignExtend,
  input  logic [1:0]            i_Size,
  input  logic [ADDR_WIDTH-1:0] i_Address,
  input  logic [31:0]           i_DataIn,
  output logic [31:0]           o_DataOut,
  output logic                  o_Valid,
  output logic                  o_MisalignErr,
  output logic                  o_Busy,
  input  logic                  i_PreloadValid,
  input  logic [7:0]            i_PreloadData,
  input  logic                  i_PreloadDone,
  output logic                  o_PreloadReady
);

  localparam int         DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [1:0] c_SZ_BYTE  = 2'b00;
  localparam logic [1:0] c_SZ_HALF  = 2'b01;
  localparam logic [1:0] c_SZ_WORD  = 2'b10;
  localparam logic [1:0] c_SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_IDLE = 2'd1,
    S_DW2  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [7:0]            r_mem [DEPTH];

  logic [31:0]           r_DataOut;
  logic                  r_Valid;
  logic                  r_MisalignErr;
  logic [ADDR_WIDTH-1:0] r_dw_addr;
  logic                  r_dw_we;

  logic                  w_misalign;
  logic                  w_acc_go;
  logic                  w_acc_we;
  logic [ADDR_WIDTH-1:0] w_acc_addr;
  logic [1:0]            w_acc_size;
  logic [ADDR_WIDTH-1:0] w_a1;
  logic [ADDR_WIDTH-1:0] w_a2;
  logic [ADDR_WIDTH-1:0] w_a3;
  logic [7:0]            w_b0;
  logic [7:0]            w_b1;
  logic [7:0]            w_b2;
  logic [7:0]            w_b3;
  logic [31:0]           w_rdata;
  logic [31:0]           w_dout_nxt;
  logic                  w_valid_nxt;
  logic                  w_err_nxt;
  logic                  w_dw_start;

`ifdef DMEM_PRELOAD_EN
  localparam logic [ADDR_WIDTH-1:0] c_PTR_LAST = '1;

  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  w_pl_we;
  logic                  w_pl_last;

  assign w_pl_we        = (r_state == S_LOAD) && i_PreloadValid;
  assign w_pl_last      = w_pl_we && (r_ptr == c_PTR_LAST);
  assign o_PreloadReady = (r_state == S_LOAD);

  // Preload pointer: restarts at 0 on reset, advances per accepted byte
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_pl_we) begin
      r_ptr <= r_ptr + ADDR_WIDTH'(1);
    end
  end
`else
  logic w_unused_preload;

  assign w_unused_preload = ^{i_PreloadValid, i_PreloadData, i_PreloadDone};
  assign o_PreloadReady   = 1'b0;
`endif

  // Alignment check of the incoming request (byte accesses are always aligned)
  always_comb begin
    w_misalign = 1'b0;
    case (i_Size)
      c_SZ_HALF:  w_misalign = i_Address[0];
      c_SZ_WORD:  w_misalign = |i_Address[1:0];
      c_SZ_DWORD: w_misalign = |i_Address[2:0];
      default:    w_misalign = 1'b0;
    endcase
  end

  // Select the memory access of this cycle: second doubleword beat or a new request
  always_comb begin
    if (r_state == S_DW2) begin
      w_acc_go   = 1'b1;
      w_acc_we   = r_dw_we;
      w_acc_addr = r_dw_addr;
      w_acc_size = c_SZ_WORD;
    end else begin
      w_acc_go   = (r_state == S_IDLE) && i_Enable && !w_misalign;
      w_acc_we   = i_ReadWrite;
      w_acc_addr = i_Address;
      w_acc_size = (i_Size == c_SZ_DWORD) ? c_SZ_WORD : i_Size;
    end
  end

  assign w_a1 = w_acc_addr + ADDR_WIDTH'(1);
  assign w_a2 = w_acc_addr + ADDR_WIDTH'(2);
  assign w_a3 = w_acc_addr + ADDR_WIDTH'(3);
  assign w_b0 = r_mem[w_acc_addr];
  assign w_b1 = r_mem[w_a1];
  assign w_b2 = r_mem[w_a2];
  assign w_b3 = r_mem[w_a3];

  // Big-endian read assembly with optional sign extension of sub-word data
  always_comb begin
    case (w_acc_size)
      c_SZ_BYTE: w_rdata = {{24{i_SignExtend & w_b0[7]}}, w_b0};
      c_SZ_HALF: w_rdata = {{16{i_SignExtend & w_b0[7]}}, w_b0, w_b1};
      default:   w_rdata = {w_b0, w_b1, w_b2, w_b3};
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_dout_nxt  = 32'h0;
    w_dw_start  = 1'b0;
    case (r_state)
      S_LOAD: begin
`ifdef DMEM_PRELOAD_EN
        if (i_PreloadDone || w_pl_last) begin
          w_state_nxt = S_IDLE;
        end
`else
        w_state_nxt = S_IDLE;
`endif
      end
      S_IDLE: begin
        if (i_Enable) begin
          w_valid_nxt = 1'b1;
          if (w_misalign) begin
            w_err_nxt = 1'b1;
          end else begin
            if (!i_ReadWrite) begin
              w_dout_nxt = w_rdata;
            end
            if (i_Size == c_SZ_DWORD) begin
              w_state_nxt = S_DW2;
              w_dw_start  = 1'b1;
            end
          end
        end
      end
      S_DW2: begin
        w_valid_nxt = 1'b1;
        if (!r_dw_we) begin
          w_dout_nxt = w_rdata;
        end
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef DMEM_PRELOAD_EN
      r_state <= S_LOAD;
`else
      r_state <= S_IDLE;
`endif
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered response and the captured context for the second doubleword beat
  always_ff @(posedge clk) begin
    if (reset) begin
      r_DataOut     <= 32'h0;
      r_Valid       <= 1'b0;
      r_MisalignErr <= 1'b0;
      r_dw_addr     <= '0;
      r_dw_we       <= 1'b0;
    end else begin
      r_DataOut     <= w_dout_nxt;
      r_Valid       <= w_valid_nxt;
      r_MisalignErr <= w_err_nxt;
      if (w_dw_start) begin
        r_dw_addr <= i_Address + ADDR_WIDTH'(4);
        r_dw_we   <= i_ReadWrite;
      end
    end
  end

  // Memory writes; contents survive reset but nothing is written on a reset edge
  always_ff @(posedge clk) begin
    if (!reset) begin
`ifdef DMEM_PRELOAD_EN
      if (w_pl_we) begin
        r_mem[r_ptr] <= i_PreloadData;
      end
`endif
      if (w_acc_go && w_acc_we) begin
        case (w_acc_size)
          c_SZ_BYTE: begin
            r_mem[w_acc_addr] <= i_DataIn[7:0];
          end
          c_SZ_HALF: begin
            r_mem[w_acc_addr] <= i_DataIn[15:8];
            r_mem[w_a1]       <= i_DataIn[7:0];
          end
          default: begin
            r_mem[w_acc_addr] <= i_DataIn[31:24];
            r_mem[w_a1]       <= i_DataIn[23:16];
            r_mem[w_a2]       <= i_DataIn[15:8];
            r_mem[w_a3]       <= i_DataIn[7:0];
          end
        endcase
      end
    end
  end

  assign o_DataOut     = r_DataOut;
  assign o_Valid       = r_Valid;
  assign o_MisalignErr = r_MisalignErr;
  assign o_Busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire
